// File: rtl/pid_seq_pkg.sv
// rtl/pid_seq_pkg.sv - shared constants and state encodings for the PID sequencer
package pid_seq_pkg;

    localparam int VEL_W = 9;

    localparam logic [7:0] FRAME_HDR  = 8'hA5;
    localparam logic [7:0] CMD_KPKD   = 8'h01;
    localparam logic [7:0] CMD_PER_LO = 8'h02;
    localparam logic [7:0] CMD_PER_HI = 8'h03;
    localparam logic [7:0] CMD_RUN    = 8'h04;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_CMD  = 2'd1,
        PS_DATA = 2'd2,
        PS_CHK  = 2'd3
    } parse_state_t;

    typedef enum logic [1:0] {
        LS_STOP    = 2'd0,
        LS_WAIT    = 2'd1,
        LS_ACTIVE  = 2'd2,
        LS_CAPTURE = 2'd3
    } loop_state_t;

    function automatic logic cmd_known(input logic [7:0] c);
        return (c == CMD_KPKD) || (c == CMD_PER_LO) || (c == CMD_PER_HI) || (c == CMD_RUN);
    endfunction

endpackage

// File: rtl/pid_cmd_parser.sv
// rtl/pid_cmd_parser.sv - 4-byte config frame parser with inter-byte timeout and checksum
module pid_cmd_parser
    import pid_seq_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 50000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       cmd_valid,
    output logic [7:0] cmd,
    output logic [7:0] data,
    output logic       cfg_err
);

    localparam int TW = $clog2(BYTE_TIMEOUT + 1);

    parse_state_t state, state_nxt;
    logic [TW-1:0] idle_cnt;
    logic          timeout;
    logic          chk_byte;
    logic          frame_ok;

    // Timeout fires on the last of BYTE_TIMEOUT consecutive idle clocks inside a frame
    assign timeout  = (state != PS_IDLE) && !rx_valid && (idle_cnt == TW'(BYTE_TIMEOUT - 1));
    assign chk_byte = (state == PS_CHK) && rx_valid;
    assign frame_ok = (rx_data == (cmd ^ data)) && cmd_known(cmd);

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PS_IDLE;
        else        state <= state_nxt;
    end

    // Frame next-state: only the header is filtered, every later byte is a field
    always_comb begin
        state_nxt = state;
        case (state)
            PS_IDLE: if (rx_valid && rx_data == FRAME_HDR) state_nxt = PS_CMD;
            PS_CMD:  if (rx_valid) state_nxt = PS_DATA; else if (timeout) state_nxt = PS_IDLE;
            PS_DATA: if (rx_valid) state_nxt = PS_CHK;  else if (timeout) state_nxt = PS_IDLE;
            PS_CHK:  if (rx_valid || timeout) state_nxt = PS_IDLE;
            default: state_nxt = PS_IDLE;
        endcase
    end

    // Accepted-frame strobe is combinational so the write lands on the CHK edge
    always_comb begin
        cmd_valid = chk_byte && frame_ok;
    end

    // Field capture, idle counting and the registered error strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd      <= '0;
            data     <= '0;
            idle_cnt <= '0;
            cfg_err  <= 1'b0;
        end else begin
            if (state == PS_CMD && rx_valid)  cmd  <= rx_data;
            if (state == PS_DATA && rx_valid) data <= rx_data;
            if (state == PS_IDLE || rx_valid || timeout) idle_cnt <= '0;
            else                                         idle_cnt <= idle_cnt + 1'b1;
            cfg_err <= chk_byte && !frame_ok;
        end
    end

endmodule

// File: rtl/pid_sequencer.sv
// rtl/pid_sequencer.sv - UART-configured periodic PID enable/capture sequencer
module pid_sequencer
    import pid_seq_pkg::*;
#(
    parameter int         PID_LAT      = 2,
    parameter int         BYTE_TIMEOUT = 50000,
    parameter int         PERIOD_RST   = 1000,
    parameter logic [7:0] KPKD_RST     = 8'hC3
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic [VEL_W-1:0] meas_vel,
    input  logic             meas_valid,
    input  logic [VEL_W-1:0] pid_vel_output,
    output logic [VEL_W-1:0] pid_current_vel,
    output logic [7:0]       pid_KpKd,
    output logic             pid_en,
    output logic [VEL_W-1:0] duty_out,
    output logic             duty_valid,
    output logic             cfg_err,
    output logic             running
);

    localparam int          LW         = (PID_LAT > 1) ? $clog2(PID_LAT) : 1;
    localparam logic [15:0] MIN_PERIOD = 16'(PID_LAT + 2);

    logic             cmd_valid;
    logic [7:0]       cmd;
    logic [7:0]       data;
    logic [15:0]      period_reg;
    logic [7:0]       kpkd_shadow;
    logic [7:0]       kpkd_next;
    logic             run_next;
    logic [15:0]      eff_period;
    logic [15:0]      reload_val;
    logic [VEL_W-1:0] meas_hold;
    logic [VEL_W-1:0] vel_sample;
    logic [15:0]      cnt;
    logic [LW-1:0]    lat_cnt;
    logic             lat_done;
    logic             tick;
    loop_state_t      state, state_nxt;

    pid_cmd_parser #(
        .BYTE_TIMEOUT (BYTE_TIMEOUT)
    ) u_parser (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .data      (data),
        .cfg_err   (cfg_err)
    );

    // Values as they will be after this edge's config write (the loop reacts to them at once)
    assign run_next   = (cmd_valid && cmd == CMD_RUN)  ? data[0] : running;
    assign kpkd_next  = (cmd_valid && cmd == CMD_KPKD) ? data    : kpkd_shadow;
    // Reload uses the registered period, so a same-cycle write waits for the following reload
    assign eff_period = (period_reg < MIN_PERIOD) ? MIN_PERIOD : period_reg;
    assign reload_val = eff_period - 16'd1;
    assign vel_sample = meas_valid ? meas_vel : meas_hold;
    assign tick       = (state == LS_WAIT) && (cnt == 16'd0);
    assign lat_done   = (lat_cnt == LW'(PID_LAT - 1));

    // Configuration registers written by accepted frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_reg  <= 16'(PERIOD_RST);
            kpkd_shadow <= KPKD_RST;
            running     <= 1'b0;
        end else if (cmd_valid) begin
            case (cmd)
                CMD_KPKD:   kpkd_shadow      <= data;
                CMD_PER_LO: period_reg[7:0]  <= data;
                CMD_PER_HI: period_reg[15:8] <= data;
                CMD_RUN:    running          <= data[0];
                default:    ;
            endcase
        end
    end

    // Hold the latest measured velocity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          meas_hold <= '0;
        else if (meas_valid) meas_hold <= meas_vel;
    end

    // Loop state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LS_STOP;
        else        state <= state_nxt;
    end

    // Loop next-state: clearing run wins over everything
    always_comb begin
        state_nxt = state;
        if (!run_next) begin
            state_nxt = LS_STOP;
        end else begin
            case (state)
                LS_STOP:    state_nxt = LS_WAIT;
                LS_WAIT:    if (tick) state_nxt = LS_ACTIVE;
                LS_ACTIVE:  if (lat_done) state_nxt = LS_CAPTURE;
                LS_CAPTURE: state_nxt = LS_WAIT;
                default:    state_nxt = LS_STOP;
            endcase
        end
    end

    // Loop combinational outputs
    always_comb begin
        pid_en = (state == LS_ACTIVE);
    end

    // Period counter keeps running through ACTIVE/CAPTURE so ticks stay exactly P apart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            lat_cnt <= '0;
        end else begin
            if (state_nxt == LS_STOP)            cnt <= '0;
            else if (state == LS_STOP || tick)   cnt <= reload_val;
            else if (cnt != 16'd0)               cnt <= cnt - 16'd1;
            if (state == LS_ACTIVE && state_nxt == LS_ACTIVE) lat_cnt <= lat_cnt + 1'b1;
            else                                              lat_cnt <= '0;
        end
    end

    // Registered datapath outputs; gains only move while the PID is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_current_vel <= '0;
            pid_KpKd        <= KPKD_RST;
            duty_out        <= '0;
            duty_valid      <= 1'b0;
        end else begin
            if (state_nxt == LS_ACTIVE && state == LS_WAIT) pid_current_vel <= vel_sample;
            if (state_nxt == LS_STOP || state_nxt == LS_WAIT) pid_KpKd <= kpkd_next;
            duty_valid <= (state == LS_CAPTURE) && run_next;
            if (state == LS_CAPTURE && run_next) duty_out <= pid_vel_output;
        end
    end

endmodule
